lsb_debounce: RTL and testbench
===============================

LSB_DEBOUNCE -- requirements
Module: lsb_debounce

Interface
REQ-001 Parameter PRESC, default 50000, sample-tick period in clk cycles (1 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter STABLE, default 4, number of consecutive differing ticks required to accept a new level; legal range 2..7.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 stb  in  1  bus strobe for this device.
REQ-006 we  in  1  bus write enable; read when stb & ~we.
REQ-007 data_in  in  32  bus write data.
REQ-008 data_out  out  32  bus read data.
REQ-009 ack  out  1  bus acknowledge.
REQ-010 btn_in_n  in  4  raw pushbuttons, active-low, asynchronous.
REQ-011 swi_in  in  10  raw slide switches, active-high, asynchronous.
REQ-012 btn_out  out  4  debounced buttons, active-high.
REQ-013 swi_out  out  10  debounced switches.
REQ-014 btn_press  out  4  one-cycle pulse per debounced button 0->1.
REQ-015 btn_rel  out  4  one-cycle pulse per debounced button 1->0.

Function
REQ-016 All 14 raw inputs SHALL pass a 2-flop synchroniser; buttons inverted after the synchroniser.
REQ-017 Prescaler SHALL count 0..PRESC-1 and wrap; tick asserted for one cycle when count = PRESC-1.
REQ-018 Per input: 3-bit stability counter; on tick, if synchronised level equals debounced level, counter <= 0.
REQ-019 On tick with levels differing and counter < STABLE-1: counter increments.
REQ-020 On tick with levels differing and counter = STABLE-1: debounced level flips, counter <= 0.
REQ-021 No counter or debounced level SHALL change on non-tick cycles.
REQ-022 Latency: level held stable SHALL appear on btn_out/swi_out at the STABLE-th tick after it leaves the synchroniser; any tick where it matches the old debounced level restarts the count.
REQ-023 btn_press[i]/btn_rel[i] SHALL be registered and high exactly in the first cycle btn_out[i] shows the new level.
REQ-024 Sticky press latch P[3:0] and release latch R[3:0] SHALL set in the same edge that raises the corresponding pulse.
REQ-025 Write (stb & we): data_in[19:16] = 1 clears P bits, data_in[23:20] = 1 clears R bits; other bits ignored.
REQ-026 Simultaneous set and clear of one latch bit: set wins.
REQ-027 Read (stb & ~we): data_out = {8'b0, R[3:0], P[3:0], btn_out[3:0], 2'b0, swi_out[9:0]}; combinational, same cycle.
REQ-028 data_out SHALL be 32'b0 whenever not reading.
REQ-029 ack SHALL equal stb (zero-wait, combinational).
REQ-030 Read SHALL NOT clear latches.

Reset
REQ-031 On rst: prescaler, all stability counters, debounced levels, pulses and P/R latches <= 0; synchronisers <= idle (buttons released, switches 0).
REQ-032 rst mid-count SHALL discard partial counts; debouncing restarts from zero after release.
REQ-033 Switches high at reset SHALL reach swi_out after STABLE ticks; no press/release events for switches exist.

Verification (PRESC=4, STABLE=4)
REQ-034 Reset: after rst, btn_out=0, swi_out=0, pulses=0, read data_out=0x00000000; ack follows stb.
REQ-035 Clean press: btn_in_n=4'b1110 held -> btn_out[0]=1 at 4th tick post-sync, btn_press=4'b0001 one cycle, read = 0x00011000.
REQ-036 Bounce: btn_in_n[1] toggled every 2 ticks for 40 ticks -> btn_out[1], btn_press[1], P[1] stay 0.
REQ-037 W1C: P=4'b0011, write 0x00010000 -> P=4'b0010; release of btn 0 coinciding with write 0x00100000 -> R[0] stays 1.
REQ-038 Switches: swi_in=0x2A5 held -> data_out[9:0]=0x2A5 after 4 ticks; 1-tick glitch to 0x000 -> no change.
REQ-039 Reset mid-operation: rst at counter=3 of a press -> btn_out stays 0, press accepted 4 full ticks after rst release.

Source files
------------

// File: rtl/lsb_debounce.sv
// Pushbutton / slide-switch debouncer with a small bus register.
// Sync, tick-sampled stability filter, edge pulses, sticky W1C latches.
module lsb_debounce #(
  parameter int PRESC  = 50000,
  parameter int STABLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  input  logic [3:0]  btn_in_n,
  input  logic [9:0]  swi_in,
  output logic [3:0]  btn_out,
  output logic [9:0]  swi_out,
  output logic [3:0]  btn_press,
  output logic [3:0]  btn_rel
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);
  localparam logic [2:0] SLAST = 3'(STABLE - 1);
  // Idle raw pattern: buttons released (high), switches low.
  localparam logic [13:0] IDLE = {4'hF, 10'h000};

  logic [13:0] sync1_q, sync2_q;
  logic [13:0] lvl;
  logic [PW-1:0] pre_q, pre_d;
  logic tick;
  logic [2:0] stab_q [14];
  logic [2:0] stab_d [14];
  logic [13:0] deb_q, deb_d;
  logic [3:0] press_q, press_d;
  logic [3:0] rel_q, rel_d;
  logic [3:0] p_q, p_d;
  logic [3:0] r_q, r_d;
  logic wr, rd;
  logic unused_bits;

  assign unused_bits = ^{data_in[31:24], data_in[15:0]};

  // Two-flop synchroniser for all raw inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
    end else begin
      sync1_q <= {btn_in_n, swi_in};
      sync2_q <= sync1_q;
    end
  end

  // Buttons become active-high after synchronisation.
  assign lvl = {~sync2_q[13:10], sync2_q[9:0]};

  // Sample-tick prescaler, wraps at PRESC-1.
  always_comb begin
    tick  = (pre_q == PLAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // Per-input stability counters and debounced levels.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 14; i++) begin
      stab_d[i] = stab_q[i];
      if (tick) begin
        if (lvl[i] == deb_q[i]) begin
          stab_d[i] = '0;
        end else if (stab_q[i] == SLAST) begin
          deb_d[i]  = lvl[i];
          stab_d[i] = '0;
        end else begin
          stab_d[i] = stab_q[i] + 3'd1;
        end
      end
    end
  end

  // Edge pulses and sticky latches; a set beats a same-cycle clear.
  always_comb begin
    wr      = stb & we;
    rd      = stb & ~we;
    press_d = deb_d[13:10] & ~deb_q[13:10];
    rel_d   = ~deb_d[13:10] & deb_q[13:10];
    p_d     = (p_q & ~({4{wr}} & data_in[19:16])) | press_d;
    r_d     = (r_q & ~({4{wr}} & data_in[23:20])) | rel_d;
  end

  // State registers for filter, pulses and latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      deb_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      p_q     <= '0;
      r_q     <= '0;
      for (int i = 0; i < 14; i++) begin
        stab_q[i] <= '0;
      end
    end else begin
      pre_q   <= pre_d;
      deb_q   <= deb_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      p_q     <= p_d;
      r_q     <= r_d;
      for (int i = 0; i < 14; i++) begin
        stab_q[i] <= stab_d[i];
      end
    end
  end

  // Zero-wait bus read mux and outputs.
  always_comb begin
    ack       = stb;
    btn_out   = deb_q[13:10];
    swi_out   = deb_q[9:0];
    btn_press = press_q;
    btn_rel   = rel_q;
    data_out  = '0;
    if (rd) begin
      data_out = {8'h00, r_q, p_q, deb_q[13:10], 2'b00, deb_q[9:0]};
    end
  end

endmodule

// File: tb/tb_lsb_debounce.sv
// Directed bench for lsb_debounce at PRESC=4, STABLE=4.
// Ticks land on every 4th edge after reset release.
module tb_lsb_debounce;

  logic        clk;
  logic        rst;
  logic        stb;
  logic        we;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic [3:0]  btn_in_n;
  logic [9:0]  swi_in;
  logic [3:0]  btn_out;
  logic [9:0]  swi_out;
  logic [3:0]  btn_press;
  logic [3:0]  btn_rel;

  int n_chk = 0;
  int n_err = 0;
  int ec = 0;
  logic mon_b1 = 1'b0;
  logic [31:0] d;

  lsb_debounce #(.PRESC(4), .STABLE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .stb       (stb),
    .we        (we),
    .data_in   (data_in),
    .data_out  (data_out),
    .ack       (ack),
    .btn_in_n  (btn_in_n),
    .swi_in    (swi_in),
    .btn_out   (btn_out),
    .swi_out   (swi_out),
    .btn_press (btn_press),
    .btn_rel   (btn_rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ec++;
      mon_b1 = mon_b1 | btn_out[1] | btn_press[1];
    end
  endtask

  task automatic to_edge(input int n);
    while (ec < n) cyc(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    ec = 0;
    mon_b1 = 1'b0;
  endtask

  task automatic rd(output logic [31:0] v);
    stb = 1'b1;
    we  = 1'b0;
    #1;
    v = data_out;
    stb = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stb = 1'b0;
    we = 1'b0;
    data_in = '0;
    btn_in_n = 4'hF;
    swi_in = '0;

    // Reset state and bus handshake.
    do_reset();
    chk("rst_btn", 32'(btn_out), 32'h0);
    chk("rst_swi", 32'(swi_out), 32'h0);
    chk("rst_pr", 32'({btn_press, btn_rel}), 32'h0);
    stb = 1'b1;
    #1;
    chk("rst_ack1", 32'(ack), 32'h1);
    chk("rst_rd", data_out, 32'h0);
    stb = 1'b0;
    #1;
    chk("rst_ack0", 32'(ack), 32'h0);
    chk("idle_dout", data_out, 32'h0);

    // Clean press of button 0.
    do_reset();
    btn_in_n = 4'b1110;
    to_edge(15);
    chk("press_e15", 32'(btn_out), 32'h0);
    to_edge(16);
    chk("press_e16", 32'(btn_out), 32'h1);
    chk("press_pls", 32'(btn_press), 32'h1);
    rd(d);
    chk("press_rd", d, 32'h0001_1000);
    to_edge(17);
    chk("press_pls0", 32'(btn_press), 32'h0);

    // Button 1 bouncing every 2 ticks never qualifies.
    btn_in_n = 4'hF;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      to_edge(1 + 8 * k);
      btn_in_n[1] = ~btn_in_n[1];
    end
    to_edge(170);
    chk("bounce_mon", 32'(mon_b1), 32'h0);
    rd(d);
    chk("bounce_rd", d, 32'h0);

    // Write-one-to-clear, set beating a coincident clear.
    do_reset();
    btn_in_n = 4'b1100;
    to_edge(17);
    rd(d);
    chk("w1c_rd0", d, 32'h0003_3000);
    stb = 1'b1;
    we = 1'b1;
    data_in = 32'h0001_0000;
    #1;
    chk("wr_dout0", data_out, 32'h0);
    chk("wr_ack", 32'(ack), 32'h1);
    cyc(1);
    stb = 1'b0;
    we = 1'b0;
    rd(d);
    chk("w1c_rd1", d, 32'h0002_3000);
    btn_in_n = 4'b1101;
    to_edge(35);
    chk("rel_e35", 32'(btn_out), 32'h3);
    stb = 1'b1;
    we = 1'b1;
    data_in = 32'h0010_0000;
    cyc(1);
    stb = 1'b0;
    we = 1'b0;
    chk("rel_pls", 32'(btn_rel), 32'h1);
    chk("rel_e36", 32'(btn_out), 32'h2);
    rd(d);
    chk("w1c_rd2", d, 32'h0012_2000);
    rd(d);
    chk("w1c_rd3", d, 32'h0012_2000);
    stb = 1'b1;
    we = 1'b1;
    data_in = 32'h0010_0000;
    cyc(1);
    stb = 1'b0;
    we = 1'b0;
    rd(d);
    chk("w1c_rd4", d, 32'h0002_2000);

    // Switches held from reset, then a one-tick glitch.
    btn_in_n = 4'hF;
    do_reset();
    swi_in = 10'h2A5;
    to_edge(15);
    chk("swi_e15", 32'(swi_out), 32'h0);
    to_edge(16);
    chk("swi_e16", 32'(swi_out), 32'h2A5);
    chk("swi_nopls", 32'(btn_press), 32'h0);
    rd(d);
    chk("swi_rd", d, 32'h0000_02A5);
    to_edge(17);
    swi_in = 10'h000;
    to_edge(21);
    swi_in = 10'h2A5;
    to_edge(22);
    chk("glitch_e22", 32'(swi_out), 32'h2A5);
    to_edge(60);
    chk("glitch_e60", 32'(swi_out), 32'h2A5);

    // Reset in the middle of a press discards the count.
    swi_in = 10'h000;
    do_reset();
    btn_in_n = 4'b1110;
    to_edge(13);
    chk("mid_e13", 32'(btn_out), 32'h0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    ec = 0;
    chk("mid_rst", 32'(btn_out), 32'h0);
    to_edge(15);
    chk("mid_e15", 32'(btn_out), 32'h0);
    to_edge(16);
    chk("mid_e16", 32'(btn_out), 32'h1);
    chk("mid_pls", 32'(btn_press), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
